// File: rtl/uart_pkg.sv
// Shared definitions for the user-project UART: RX entry layout, default sizing
// and the character-timeout helper used by the integrator.
package uart_pkg;

  localparam int UART_RX_DEPTH = 16;
  localparam int UART_DATA_W   = 8;

  // One received character as stored in the RX FIFO.
  typedef struct packed {
    logic                   frame_err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

  localparam int RX_ENTRY_W = $bits(rx_entry_t);

  // Four character times of ten bit periods each.
  localparam int CHAR_TIMEOUT_FACTOR = 40;

  function automatic int rx_entry_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic logic [31:0] char_timeout_cycles(input logic [31:0] clk_div);
    return 32'(CHAR_TIMEOUT_FACTOR) * clk_div;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH flop array with one synchronous write port and one
// asynchronous read port; shared by the RX and TX FIFOs.
module uart_fifo_mem #(
  parameter int  DEPTH  = 16,
  parameter int  WIDTH  = 9,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  // Contents need no reset: readers gate the output with their own empty flag.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer between the UART receiver and the CSR block: show-ahead
// FIFO with sticky overflow, fill-threshold and character-timeout interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int  DEPTH  = UART_RX_DEPTH,
  parameter int  DATA_W = UART_DATA_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_err,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_frame_err,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  input  logic              flush,
  input  logic [ADDR_W:0]   thresh,
  input  logic [31:0]       timeout_cycles,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic              irq
);

  localparam int ENTRY_W = rx_entry_w(DATA_W);

  // Handshake: wr_valid is a one-cycle strobe with no back-pressure (a byte
  // that cannot be stored is dropped and flagged); rd_en pops the show-ahead
  // entry on the edge it is sampled high, and is ignored while empty.

  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        to_cnt_q, to_cnt_d;
  logic               to_flag_q, to_flag_d;
  logic               irq_q, irq_d;

  logic               do_push;
  logic               do_pop;
  logic               drop;
  logic               thresh_hit;
  logic [ENTRY_W-1:0] rd_entry;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign count = wr_ptr_q - rd_ptr_q;

  // A pop frees the slot the push lands in, so a full FIFO still accepts a
  // byte when the CSR side reads in the same cycle.
  assign do_pop  = rd_en && !empty && !flush;
  assign do_push = wr_valid && !flush && (!full || do_pop);
  assign drop    = wr_valid && !flush && full && !do_pop;

  assign thresh_hit = (thresh != '0) && (count >= thresh);

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (wb_clk_i),
    .we    (do_push),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata ({wr_frame_err, wr_data}),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rd_entry)
  );

  assign rd_data      = empty ? '0   : rd_entry[DATA_W-1:0];
  assign rd_frame_err = empty ? 1'b0 : rd_entry[DATA_W];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Set beats clear so a drop coinciding with a clear is never lost.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  // The counter parks at timeout_cycles once reached, so the flag fires once
  // per idle period and only re-arms after activity restarts the count.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_flag_d = to_flag_q;
    if (flush || do_push || do_pop) begin
      to_cnt_d  = '0;
      to_flag_d = 1'b0;
    end else if (empty) begin
      to_cnt_d  = '0;
    end else if ((timeout_cycles != '0) && (to_cnt_q < timeout_cycles)) begin
      to_cnt_d = to_cnt_q + 32'd1;
      if (to_cnt_q + 32'd1 == timeout_cycles) to_flag_d = 1'b1;
    end
  end

  always_comb begin
    irq_d = thresh_hit || to_flag_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      to_cnt_q   <= '0;
      to_flag_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      to_cnt_q   <= to_cnt_d;
      to_flag_q  <= to_flag_d;
      irq_q      <= irq_d;
    end
  end

  assign overflow = overflow_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_err;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_frame_err;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              flush;
  logic [ADDR_W:0]   thresh;
  logic [31:0]       timeout_cycles;
  logic              overflow;
  logic              clr_overflow;
  logic              irq;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_frame_err   (wr_frame_err),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_frame_err   (rd_frame_err),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .flush          (flush),
    .thresh         (thresh),
    .timeout_cycles (timeout_cycles),
    .overflow       (overflow),
    .clr_overflow   (clr_overflow),
    .irq            (irq)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    wr_valid     = 1'b0;
    wr_data      = '0;
    wr_frame_err = 1'b0;
    rd_en        = 1'b0;
    flush        = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic fe);
    wr_valid = 1'b1; wr_data = d; wr_frame_err = fe;
    step();
    wr_valid = 1'b0; wr_frame_err = 1'b0;
  endtask

  task automatic pop_expect(input string nm, input logic [7:0] d);
    check(nm, 32'(rd_data), 32'(d));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    #12;
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       fe;
    logic       re;
    logic       fl;
    logic [4:0] e_count;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_data;
    logic       e_fe;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[9];

  // ---------------- scoreboard / reference model ----------------
  logic [DATA_W:0] exp_q[$];
  logic            m_ovf;
  logic            m_flag;
  logic            m_irq;
  int              m_idle;

  task automatic model_edge(input logic wv, input logic [7:0] wd, input logic fe,
                            input logic re, input logic fl, input logic clr,
                            input int th, input int tc);
    bit was_empty, was_full, pop_ok, push_ok, dropped, act;
    m_irq     = ((th != 0) && (exp_q.size() >= th)) || m_flag;
    was_empty = (exp_q.size() == 0);
    was_full  = (exp_q.size() == DEPTH);
    pop_ok = 0; push_ok = 0; dropped = 0;
    if (fl) begin
      exp_q.delete();
    end else begin
      pop_ok  = re && !was_empty;
      push_ok = wv && (!was_full || pop_ok);
      dropped = wv && was_full && !pop_ok;
      if (pop_ok)  void'(exp_q.pop_front());
      if (push_ok) exp_q.push_back({fe, wd});
    end
    if (clr)     m_ovf = 1'b0;
    if (dropped) m_ovf = 1'b1;
    act = fl || push_ok || pop_ok;
    if (act) begin
      m_idle = 0;
      m_flag = 1'b0;
    end else if (was_empty) begin
      m_idle = 0;
    end else if ((tc != 0) && (m_idle < tc)) begin
      m_idle++;
      if (m_idle == tc) m_flag = 1'b1;
    end
  endtask

  task automatic compare_model();
    logic [DATA_W:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("rnd_count", 32'(count), 32'(exp_q.size()));
    check("rnd_empty", 32'(empty), 32'(exp_q.size() == 0));
    check("rnd_full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("rnd_rd_data", 32'(rd_data), 32'(head[DATA_W-1:0]));
    check("rnd_rd_frame_err", 32'(rd_frame_err), 32'(head[DATA_W]));
    check("rnd_overflow", 32'(overflow), 32'(m_ovf));
    check("rnd_irq", 32'(irq), 32'(m_irq));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    clear_in();
    thresh = '0;
    timeout_cycles = '0;

    vecs[0] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    // Reset values
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_frame_err", 32'(rd_frame_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Vector table (includes the frame-error path)
    for (int i = 0; i < 9; i++) begin
      wr_valid = vecs[i].wv; wr_data = vecs[i].wd; wr_frame_err = vecs[i].fe;
      rd_en = vecs[i].re; flush = vecs[i].fl;
      step();
      clear_in();
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d_rd_frame_err", i), 32'(rd_frame_err), 32'(vecs[i].e_fe));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
    end

    // Fill and wrap
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    for (int i = 0; i < 4; i++) pop_expect("wrap_pop_a", 8'(i));
    for (int i = 0; i < 4; i++) push(8'(8'hA0 + i), 1'b0);
    check("wrap_full", 32'(full), 32'd1);
    for (int i = 4; i < 16; i++) pop_expect("wrap_pop_b", 8'(i));
    for (int i = 0; i < 4; i++) pop_expect("wrap_pop_c", 8'(8'hA0 + i));
    check("wrap_empty", 32'(empty), 32'd1);

    // Overflow
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    push(8'h55, 1'b0);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_head", 32'(rd_data), 32'h00);
    wr_valid = 1'b1; wr_data = 8'h66; rd_en = 1'b1;
    step();
    clear_in();
    check("ovf_pushpop_count", 32'(count), 32'd16);
    check("ovf_pushpop_flag", 32'(overflow), 32'd1);
    check("ovf_pushpop_head", 32'(rd_data), 32'h01);
    clr_overflow = 1'b1;
    step();
    clear_in();
    check("ovf_clear", 32'(overflow), 32'd0);
    wr_valid = 1'b1; wr_data = 8'h77; clr_overflow = 1'b1;
    step();
    clear_in();
    check("ovf_set_wins", 32'(overflow), 32'd1);
    for (int i = 1; i < 16; i++) pop_expect("ovf_drain", 8'(i));
    pop_expect("ovf_drain_last", 8'h66);
    check("ovf_drain_empty", 32'(empty), 32'd1);
    check("ovf_flush_keeps", 32'(overflow), 32'd1);

    // Threshold IRQ
    thresh = 5'd4;
    for (int i = 1; i <= 3; i++) push(8'(i), 1'b0);
    step();
    check("thr_below", 32'(irq), 32'd0);
    push(8'h04, 1'b0);
    check("thr_reg_delay", 32'(irq), 32'd0);
    step();
    check("thr_hit", 32'(irq), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("thr_pop_delay", 32'(irq), 32'd1);
    step();
    check("thr_pop_clear", 32'(irq), 32'd0);
    thresh = 5'd0;
    do_flush();
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    step();
    check("thr_disabled_full", 32'(full), 32'd1);
    check("thr_disabled_irq", 32'(irq), 32'd0);
    do_flush();

    // Character timeout
    timeout_cycles = 32'd100;
    step();
    push(8'h77, 1'b0);
    n = 0;
    while (!irq && n < 300) begin step(); n++; end
    check("to_latency", 32'(n), 32'd101);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("to_pop_delay", 32'(irq), 32'd1);
    step();
    check("to_pop_clear", 32'(irq), 32'd0);
    push(8'h78, 1'b0);
    for (int i = 0; i < 50; i++) step();
    check("to_mid_idle", 32'(irq), 32'd0);
    push(8'h79, 1'b0);
    n = 0;
    while (!irq && n < 300) begin step(); n++; end
    check("to_restart_latency", 32'(n), 32'd101);
    do_flush();
    check("to_flush_count", 32'(count), 32'd0);
    step();
    check("to_flush_irq", 32'(irq), 32'd0);
    timeout_cycles = '0;

    // Asynchronous reset mid-operation
    thresh = 5'd4;
    for (int i = 0; i < 5; i++) push(8'(8'h90 + i), 1'b0);
    step();
    check("arst_pre_irq", 32'(irq), 32'd1);
    check("arst_pre_ovf", 32'(overflow), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_count", 32'(count), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    thresh = '0;
    step();

    // Randomized run against the reference model
    do_reset();
    exp_q.delete();
    m_ovf = 1'b0; m_flag = 1'b0; m_irq = 1'b0; m_idle = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int ph, pw, pr;
      ph = (cyc / 200) % 3;
      pw = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
      pr = (ph == 0) ? 20 : (ph == 1) ? 75 : 50;
      if (cyc % 600 == 0) begin
        thresh         = 5'($urandom_range(0, 16));
        timeout_cycles = 32'($urandom_range(0, 12));
      end
      wr_valid     = ($urandom_range(0, 99) < pw);
      wr_data      = 8'($urandom);
      wr_frame_err = ($urandom_range(0, 9) == 0);
      rd_en        = ($urandom_range(0, 99) < pr);
      flush        = ($urandom_range(0, 99) == 0);
      clr_overflow = ($urandom_range(0, 29) == 0);
      model_edge(wr_valid, wr_data, wr_frame_err, rd_en, flush, clr_overflow,
                 int'(thresh), int'(timeout_cycles));
      step();
      compare_model();
    end
    clear_in();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
